mult_seq_ctrl: RTL and testbench



---
 rtl/mult_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-and-add multiplier sharing one N_BITS adder over N_BITS cycles.
// Optional MULT_SEQ_EARLY_TERM_EN finishes as soon as no multiplier bits remain.
module mult_seq_ctrl #(
    parameter int N_BITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [N_BITS-1:0]     i_a,
    input  logic [N_BITS-1:0]     i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*N_BITS-1:0]   o_mult,
    output logic                  o_busy
);

    localparam int CW = $clog2(N_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_BITS-1:0]     mcand_q, mcand_d;
    logic [2*N_BITS-1:0]   acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*N_BITS-1:0]   mult_q, mult_d;

    logic [N_BITS:0]       sum_c;
    logic [2*N_BITS-1:0]   acc_step;

    assign sum_c = {1'b0, acc_q[2*N_BITS-1:N_BITS]}
                 + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {sum_c, acc_q[N_BITS-1:1]};

`ifdef MULT_SEQ_EARLY_TERM_EN
    logic [N_BITS-1:0]     ones;
    logic [N_BITS-1:0]     rem_bits;
    logic [CW-1:0]         sh;
    logic [2*N_BITS-1:0]   acc_flush;

    // Low bits not yet consumed are the remaining multiplier bits.
    assign ones      = '1;
    assign rem_bits  = acc_q[N_BITS-1:0] & (ones >> cnt_q);
    assign sh        = CW'(N_BITS) - cnt_q;
    assign acc_flush = acc_q >> sh;
`endif

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mult_d  = mult_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    mcand_d = i_a;
                    acc_d   = {{N_BITS{1'b0}}, i_b};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef MULT_SEQ_EARLY_TERM_EN
                if (rem_bits == '0) begin
                    acc_d   = acc_flush;
                    mult_d  = acc_flush;
                    state_d = DONE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(N_BITS - 1)) begin
                        mult_d  = acc_step;
                        state_d = DONE;
                    end
                end
`else
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N_BITS - 1)) begin
                    mult_d  = acc_step;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mult_q  <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mult_q  <= mult_d;
        end
    end

    // Product lives in its own register so reloading acc never disturbs it.
    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == CALC);
    assign o_valid = (state_q == DONE);
    assign o_mult  = mult_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl (N_BITS=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_a;
    logic [3:0] i_b;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_mult;
    logic       o_busy;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;

    mult_seq_ctrl #(.N_BITS(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_mult  (o_mult),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one operand pair; returns after the accepting edge.
    task automatic start(input logic [3:0] a, input logic [3:0] b);
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_a     = 4'hx;
        i_b     = 4'hx;
    endtask

    // Edges counted with the accepting edge as the first one.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!o_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    int lat;
    int lat_b0;
    int seen;
    int t0;

    initial begin
`ifdef MULT_SEQ_EARLY_TERM_EN
        lat_b0 = 2;
`else
        lat_b0 = 5;
`endif
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_mult", o_mult, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start(4'd13, 4'd11);
        check("13x11_ready_low", o_ready, 0);
        check("13x11_busy", o_busy, 1);
        wait_valid(lat);
        check("13x11_lat", lat, 5);
        check("13x11_mult", {o_valid, o_mult}, {1'b1, 8'h8F});
        check("13x11_busy_done", o_busy, 0);
        check("13x11_ready_done", o_ready, 0);
        @(negedge clk);
        check("13x11_valid_drop", o_valid, 0);
        check("13x11_ready_back", o_ready, 1);
        check("13x11_mult_hold", o_mult, 143);

        start(4'd15, 4'd15);
        wait_valid(lat);
        check("15x15_lat", lat, 5);
        check("15x15_mult", {o_valid, o_mult}, {1'b1, 8'hE1});
        @(negedge clk);

        start(4'd0, 4'd9);
        wait_valid(lat);
        check("0x9_lat", lat, 5);
        check("0x9_mult", {o_valid, o_mult}, {1'b1, 8'd0});
        @(negedge clk);

        start(4'd9, 4'd0);
        wait_valid(lat);
        check("9x0_lat", lat, lat_b0);
        check("9x0_mult", {o_valid, o_mult}, {1'b1, 8'd0});
        @(negedge clk);

        i_ready = 1'b0;
        start(4'd6, 4'd7);
        wait_valid(lat);
        check("6x7_lat", lat, 5);
        i_valid = 1'b1;
        i_a     = 4'd1;
        i_b     = 4'd1;
        for (int k = 0; k < 10; k++) begin
            check("6x7_hold_valid", o_valid, 1);
            check("6x7_hold_mult", o_mult, 42);
            check("6x7_hold_ready", o_ready, 0);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check("6x7_valid_drop", o_valid, 0);
        check("6x7_ready_back", o_ready, 1);
        check("6x7_mult_kept", o_mult, 42);

        start(4'd12, 4'd12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", o_ready, 1);
        check("midrst_valid", o_valid, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_mult", o_mult, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        start(4'd3, 4'd5);
        wait_valid(lat);
        check("3x5_mult", {o_valid, o_mult}, {1'b1, 8'd15});
        @(negedge clk);

        t0 = cyc;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start(4'(a), 4'(b));
                wait_valid(lat);
                check($sformatf("sweep_%0dx%0d", a, b),
                      {o_valid, o_mult}, {1'b1, 8'(a * b)});
                @(negedge clk);
            end
        end
`ifndef MULT_SEQ_EARLY_TERM_EN
        check("sweep_period", cyc - t0, 256 * 6);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
